// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift/add-3, one bit per clock).
// A valid/ready handshake is used on both the input and the output side.
// Optional: `define LEADING_ZERO_BLANK_EN to produce blank_mask, which flags
// leading-zero digits. Without it, blank_mask is tied to zero.
module bin2bcd_seq #(
  parameter int N     = 20,
  parameter int D     = 6,
  parameter int CNT_W = 5
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] out_bcd,
  output logic           out_ovf,
  output logic [D-1:0]   blank_mask
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     bin_q;
  logic [4*D-1:0]   dig_q;
  logic [4*D-1:0]   dig_adj;
  logic [4*D-1:0]   bcd_q;
  logic             ovf_acc_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  // Cycle after the N-th shift: the digit registers hold the final result.
  assign last      = (state_q == SHIFT) && (cnt_q == '0);
  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;

  // Per-digit add-3 correction. Each digit is handled independently and
  // there is no carry between digits.
  for (genvar k = 0; k < D; k++) begin : g_adj
    assign dig_adj[4*k +: 4] = (dig_q[4*k +: 4] >= 4'd5) ? dig_q[4*k +: 4] + 4'd3
                                                         : dig_q[4*k +: 4];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)    state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Shift engine: load on accept, then do one corrected shift per cycle.
  // Any bit leaving the top digit marks an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      dig_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      bin_q     <= in_data;
      dig_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= CNT_W'(N);
    end else if (state_q == SHIFT && cnt_q != '0) begin
      dig_q     <= {dig_adj[4*D-2:0], bin_q[N-1]};
      bin_q     <= {bin_q[N-2:0], 1'b0};
      ovf_acc_q <= ovf_acc_q | dig_adj[4*D-1];
      cnt_q     <= cnt_q - 1'b1;
    end
  end

  // Result registers. They are loaded once per conversion and then held
  // through DONE and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last) begin
      bcd_q <= dig_q;
      ovf_q <= ovf_acc_q;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [D-1:0] blank_d, blank_q;
  logic         seen_nz;

  // A digit is blanked while no nonzero digit has been found above it.
  // Digit 0 is never blanked.
  always_comb begin
    blank_d = '0;
    seen_nz = 1'b0;
    for (int i = D-1; i >= 1; i--) begin
      if (dig_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank_d[i] = ~seen_nz;
    end
  end

  // Blank mask is captured together with the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    blank_q <= '0;
    else if (last) blank_q <= blank_d;
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. It uses a decimal-arithmetic reference
// model and covers the default build (N=20, D=6) plus small N=8 instances.
module tb_bin2bcd_seq;
  localparam int N = 20;
  localparam int D = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
  logic [N-1:0]   in_data = '0;
  logic [4*D-1:0] out_bcd;
  logic [D-1:0]   blank_mask;

  bin2bcd_seq #(.N(N), .D(D), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_ovf(out_ovf), .blank_mask(blank_mask));

  // Small instances: N=8 with D=3 and with D=2
  logic        s_valid = 1'b0;
  logic [7:0]  s3_data = '0, s2_data = '0;
  logic        s3_ready, s3_ovld, s3_ovf, s2_ready, s2_ovld, s2_ovf;
  logic [11:0] s3_bcd;
  logic [7:0]  s2_bcd;
  logic [2:0]  s3_blank;
  logic [1:0]  s2_blank;

  bin2bcd_seq #(.N(8), .D(3), .CNT_W(4)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s3_ready),
    .in_data(s3_data), .out_valid(s3_ovld), .out_ready(1'b1),
    .out_bcd(s3_bcd), .out_ovf(s3_ovf), .blank_mask(s3_blank));

  bin2bcd_seq #(.N(8), .D(2), .CNT_W(4)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s2_ready),
    .in_data(s2_data), .out_valid(s2_ovld), .out_ready(1'b1),
    .out_bcd(s2_bcd), .out_ovf(s2_ovf), .blank_mask(s2_blank));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain decimal arithmetic
  function automatic logic [23:0] ref_bcd(input longint v, input int d);
    longint r;
    logic [23:0] res;
    r = v % (64'd10 ** d);
    res = '0;
    for (int i = 0; i < d; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic bit ref_ovf(input longint v, input int d);
    return v >= (64'd10 ** d);
  endfunction

  function automatic logic [5:0] ref_blank(input longint v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    longint r;
    int nd;
    logic [5:0] m;
    r = v % (64'd10 ** d);
    nd = 1;
    while (r >= 10) begin r = r / 10; nd++; end
    m = '0;
    for (int k = nd; k < d; k++) m[k] = 1'b1;
    return m;
`else
    return 6'd0;
`endif
  endfunction

  // Expectation for the conversion currently in flight
  logic           exp_pending = 1'b0;
  logic [4*D-1:0] exp_bcd = '0;
  logic           exp_ovf = 1'b0;
  logic [D-1:0]   exp_blank = '0;
  logic [4*D-1:0] last_bcd;
  logic           last_ovf;
  logic [D-1:0]   last_blank;

  // Compare process: whenever a result is presented, it must match the model.
  // This check repeats on every cycle of backpressure.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("unexpected out_valid", exp_pending, 1'b1);
      chk("out_bcd", out_bcd, exp_bcd);
      chk("out_ovf", out_ovf, exp_ovf);
      chk("blank_mask", blank_mask, exp_blank);
      chk("in_ready in DONE", in_ready, 1'b0);
    end
  end

  task automatic accept(input longint v);
    int n;
    @(negedge clk);
    in_data  = N'(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_data     = N'($urandom);          // data after acceptance must not matter
    exp_bcd     = ref_bcd(v, D);
    exp_ovf     = ref_ovf(v, D);
    exp_blank   = ref_blank(v, D);
    exp_pending = 1'b1;
  endtask

  task automatic finish(input int hold);
    int k;
    k = 0;
    do begin
      @(posedge clk); k++;
      @(negedge clk);
    end while (!out_valid && k < 200);
    chk("latency", k, N + 1);
    last_bcd = out_bcd; last_ovf = out_ovf; last_blank = blank_mask;
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = N'(777);
      repeat (hold) begin
        @(negedge clk);
        chk("in_ready under backpressure", in_ready, 1'b0);
        chk("out_valid held", out_valid, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1 exp_pending = 1'b0;
    @(negedge clk);
    chk("out_valid drop", out_valid, 1'b0);
    chk("in_ready idle", in_ready, 1'b1);
    chk("out_bcd hold", out_bcd, last_bcd);
  endtask

  task automatic conv(input longint v, input int hold);
    accept(v);
    finish(hold);
  endtask

  initial begin
    longint v;
    int k;
    // Reset state
    #1;
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_bcd", out_bcd, 0);
    chk("rst out_ovf", out_ovf, 1'b0);
    chk("rst blank", blank_mask, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values, each also pinned to a literal expectation
    conv(123456, 0);
    chk("lit 123456", last_bcd, 24'h123456);
    chk("lit 123456 ovf", last_ovf, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit 123456 blank", last_blank, 6'b000000);
`endif
    conv(0, 0);
    chk("lit 0", last_bcd, 24'h000000);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit 0 blank", last_blank, 6'b111110);
`endif
    conv(42, 0);
    chk("lit 42", last_bcd, 24'h000042);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit 42 blank", last_blank, 6'b111100);
`endif
    conv(999999, 0);
    chk("lit 999999", last_bcd, 24'h999999);
    chk("lit 999999 ovf", last_ovf, 1'b0);
    conv(1000000, 0);
    chk("lit 1000000", last_bcd, 24'h000000);
    chk("lit 1000000 ovf", last_ovf, 1'b1);
    conv(1048575, 0);
    chk("lit 1048575", last_bcd, 24'h048575);
    chk("lit 1048575 ovf", last_ovf, 1'b1);

    // Backpressure: 777 is offered during DONE and ignored, then re-presented
    conv(314159, 10);
    chk("lit bp", last_bcd, 24'h314159);
    conv(777, 0);
    chk("lit 777", last_bcd, 24'h000777);

    // Asynchronous reset in the middle of a conversion
    accept(654321);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", in_ready, 1'b1);
    chk("mid rst out_valid", out_valid, 1'b0);
    chk("mid rst out_bcd", out_bcd, 0);
    chk("mid rst out_ovf", out_ovf, 1'b0);
    chk("mid rst blank", blank_mask, 0);
    exp_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    conv(31, 0);
    chk("lit 31", last_bcd, 24'h000031);

    // Randomized conversions with random backpressure
    for (int i = 0; i < 40; i++) begin
      v = longint'($urandom_range(0, (1 << N) - 1));
      if (i % 8 == 0) v = 999990 + longint'($urandom_range(0, 20));
      conv(v, int'($urandom_range(0, 3)));
    end

    // Small instances: N=8, D=3 / D=2
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      a = (i == 0) ? 8'd255 : 8'($urandom);
      b = (i == 0) ? 8'd100 : 8'($urandom);
      @(negedge clk);
      s3_data = a; s2_data = b; s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      k = 0;
      do begin
        @(posedge clk); k++;
        @(negedge clk);
      end while (!s3_ovld && k < 100);
      chk("s3 latency", k, 9);
      chk("s2 valid", s2_ovld, 1'b1);
      chk("s3 bcd", s3_bcd, ref_bcd(longint'(a), 3));
      chk("s3 ovf", s3_ovf, ref_ovf(longint'(a), 3));
      chk("s3 blank", s3_blank, ref_blank(longint'(a), 3));
      chk("s2 bcd", s2_bcd, ref_bcd(longint'(b), 2));
      chk("s2 ovf", s2_ovf, ref_ovf(longint'(b), 2));
      chk("s2 blank", s2_blank, ref_blank(longint'(b), 2));
      if (i == 0) begin
        chk("lit s3 255", s3_bcd, 12'h255);
        chk("lit s3 ovf", s3_ovf, 1'b0);
        chk("lit s2 100", s2_bcd, 8'h00);
        chk("lit s2 ovf", s2_ovf, 1'b1);
      end
      @(negedge clk);
      chk("s3 ready", s3_ready, 1'b1);
      chk("s2 ready", s2_ready, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter for the display path. It uses the add-3 / shift (double-dabble) algorithm and processes one input bit per clock. It replaces combinational conversion, which does not close timing at larger widths. A valid/ready handshake on both sides lets it sit between the counter/timer logic and the 7-segment scan driver. It also flags values that do not fit in the configured digit count.

Parameters:
N, 20, binary input width (N >= 4)
D, 6, number of BCD digits produced (D >= 1); output width 4*D
CNT_W, 5, width of internal bit counter; must satisfy 2^CNT_W > N

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a new value
in_data  in  N  unsigned binary value
out_valid  out  1  out_bcd/out_ovf hold a finished result
out_ready  in  1  consumer accepts result
out_bcd  out  4*D  BCD digits; [4*D-1:4*D-4] most significant digit, [3:0] units
out_ovf  out  1  in_data > 10^D - 1; out_bcd then holds the value mod 10^D
blank_mask  out  D  bit k = 1 -> digit k is a leading zero (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, blank_mask=0, counter=0, shift registers=0.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch in_data into the bin shift register, clear digit registers and the ovf accumulator, set counter=N, go to SHIFT.
- SHIFT (in_ready=0) — each cycle, in order:
  1. Every digit >= 5 gets +3 (4-bit, no carry between digits).
  2. The {digits, bin} vector shifts left 1; the bin MSB enters digit 0 LSB.
  3. The bit leaving the top digit MSB is ORed into the ovf accumulator.
  4. counter decrements.
  - When the counter reaches 0 after N shifts, go to DONE.
- DONE:
  - out_valid=1; out_bcd, out_ovf and blank_mask are stable and unchanged until handshake.
  - On out_valid&&out_ready: go to IDLE at the next edge; out_valid drops, out_bcd holds its last value.
- Latency: acceptance at edge T -> out_valid=1 after edge T+N+1 (default 21 cycles).
- Throughput: one conversion per N+2 cycles minimum. in_ready is low in SHIFT and DONE, so in_valid is ignored there and not queued.
- in_data is sampled only at acceptance; later changes have no effect.
- Overflow:
  - out_ovf=1 iff any 1 bit is shifted out of the top digit.
  - This is equivalent to in_data >= 10^D. When N is too small for such values to occur, out_ovf is constant 0.
- Every produced digit is in 0..9 in all cases, including overflow.
- Reset mid-SHIFT or mid-DONE: the conversion is abandoned and all outputs return to reset values immediately (asynchronous). No result is emitted.
- out_ready held high with no pending result: no effect.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - In DONE, blank_mask[k]=1 for every digit k above the most significant nonzero digit.
  - Digit 0 is never blanked, so value 0 gives only digit 0 unblanked.
  - blank_mask is registered together with out_bcd and has the same valid timing.
- Not defined: blank_mask is tied to all zeros and the blanking logic is not synthesised.

Test Plan:
- Reset, then in_data=123456 with in_valid pulse, out_ready=1 -> out_bcd=24'h123456, out_ovf=0, out_valid high exactly 21 cycles after acceptance edge; with macro, blank_mask=6'b000000.
- in_data=0 -> out_bcd=24'h000000, out_ovf=0; with macro, blank_mask=6'b111110. in_data=42 -> out_bcd=24'h000042, blank_mask=6'b111100.
- in_data=999999 -> out_bcd=24'h999999, out_ovf=0; then in_data=1000000 -> out_bcd=24'h000000, out_ovf=1; then in_data=1048575 -> out_bcd=24'h048575, out_ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid=1 value 777 is ignored. Raising out_ready -> IDLE next cycle; re-presented 777 -> 24'h000777.
- Reset asserted at shift 8 of a conversion of 654321 -> all outputs 0 and in_ready=1 without waiting for an edge. After release, a new conversion of 31 -> 24'h000031 with normal latency.
- Parameter sweep N=8,D=3: in_data=255 -> out_bcd=12'h255, out_ovf=0, latency 9 cycles. N=8,D=2: in_data=100 -> 8'h00, out_ovf=1.
